// File: rtl/pes_siso_ctrl.sv
// Loopback frame controller for a pes_siso shift register: serialises a word into the register,
// recaptures it DEPTH cycles later and reports match and mismatch count.
// Optional even-parity bit enabled by defining PES_SISO_CTRL_PARITY_EN.
module pes_siso_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             sr_serial_in,
  input  logic             sr_serial_out,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_match,
  output logic             rx_parity_err,
  output logic [7:0]       mismatch_cnt
);

`ifdef PES_SISO_CTRL_PARITY_EN
  localparam int unsigned ParBits = 1;
`else
  localparam int unsigned ParBits = 0;
`endif
  localparam int unsigned N  = WIDTH + ParBits;
  localparam int unsigned CW = $clog2(N + DEPTH);
  localparam logic [CW-1:0] LastCyc = CW'(N + DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_match_q, rx_match_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] tx_ord;
`ifdef PES_SISO_CTRL_PARITY_EN
  logic             cap_par_q, cap_par_d;
  logic             perr_q, perr_d;
`endif

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    shadow_d     = shadow_q;
    cap_d        = cap_q;
    rx_data_d    = rx_data_q;
    rx_match_d   = rx_match_q;
    cnt_d        = cnt_q;
    tx_ready     = 1'b0;
    sr_serial_in = 1'b0;
`ifdef PES_SISO_CTRL_PARITY_EN
    cap_par_d    = cap_par_q;
    perr_d       = perr_q;
`endif

    // tx_ord[k] is the data bit launched in SHIFT cycle k
    for (int unsigned i = 0; i < WIDTH; i++) begin
      tx_ord[i] = shadow_q[(MSB_FIRST != 0) ? (WIDTH - 1 - i) : i];
    end

    unique case (state_q)
      StIdle: begin
        tx_ready = ~reset;
        if (tx_valid && !reset) begin
          shadow_d = tx_data;
          cyc_d    = '0;
          state_d  = StShift;
        end
      end

      StShift: begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (cyc_q == CW'(i)) sr_serial_in = tx_ord[i];
        end
`ifdef PES_SISO_CTRL_PARITY_EN
        if (cyc_q == CW'(WIDTH)) sr_serial_in = ^shadow_q;
`endif
        // Bit launched in cycle k emerges from the register in cycle k+DEPTH
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (cyc_q == CW'(i + DEPTH)) begin
            cap_d[(MSB_FIRST != 0) ? (WIDTH - 1 - i) : i] = sr_serial_out;
          end
        end
`ifdef PES_SISO_CTRL_PARITY_EN
        if (cyc_q == CW'(WIDTH + DEPTH)) cap_par_d = sr_serial_out;
`endif
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == LastCyc) begin
          state_d   = StDone;
          rx_data_d = cap_d;
`ifdef PES_SISO_CTRL_PARITY_EN
          perr_d     = cap_par_d ^ (^cap_d);
          rx_match_d = (cap_d == shadow_q) && !perr_d;
`else
          rx_match_d = (cap_d == shadow_q);
`endif
          if (!rx_match_d && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cyc_q      <= '0;
      shadow_q   <= '0;
      cap_q      <= '0;
      rx_data_q  <= '0;
      rx_match_q <= 1'b0;
      cnt_q      <= 8'd0;
`ifdef PES_SISO_CTRL_PARITY_EN
      cap_par_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      shadow_q   <= shadow_d;
      cap_q      <= cap_d;
      rx_data_q  <= rx_data_d;
      rx_match_q <= rx_match_d;
      cnt_q      <= cnt_d;
`ifdef PES_SISO_CTRL_PARITY_EN
      cap_par_q  <= cap_par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign busy         = (state_q != StIdle);
  assign rx_valid     = (state_q == StDone);
  assign rx_data      = rx_data_q;
  assign rx_match     = rx_match_q;
  assign mismatch_cnt = cnt_q;
`ifdef PES_SISO_CTRL_PARITY_EN
  assign rx_parity_err = perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_pes_siso_ctrl.sv
// Directed bench for pes_siso_ctrl with a behavioural DEPTH-stage pes_siso in loopback
// and bench-controlled fault injection on the returning serial stream.
module tb_pes_siso_ctrl;

  localparam int W = 8;
  localparam int D = 4;
`ifdef PES_SISO_CTRL_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int Lat = NB + D + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic         sr_serial_in;
  logic         sr_serial_out;
  logic         busy;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_match;
  logic         rx_parity_err;
  logic [7:0]   mismatch_cnt;

  int errors = 0;
  int checks = 0;

  logic [D-1:0] sr_q = '0;
  logic         inv_all = 1'b0;
  logic         flip_par = 1'b0;
  int           sc = 0;

  always #5 clk = ~clk;

  pes_siso_ctrl #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .sr_serial_in  (sr_serial_in),
    .sr_serial_out (sr_serial_out),
    .busy          (busy),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_match      (rx_match),
    .rx_parity_err (rx_parity_err),
    .mismatch_cnt  (mismatch_cnt)
  );

  // Behavioural pes_siso plus a cycle-since-accept counter for targeted bit flips
  always @(posedge clk) begin
    sr_q <= {sr_q[D-2:0], sr_serial_in};
    if (tx_valid && tx_ready) sc <= 0;
    else sc <= sc + 1;
  end
  assign sr_serial_out = sr_q[D-1] ^ inv_all ^ (flip_par && (sc == W + D));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [W-1:0] d, output int lat);
    int w;
    lat = -1;
    tx_data = d;
    tx_valid = 1'b1;
    w = 0;
    while (!tx_ready && w < 50) begin
      tick();
      w++;
    end
    tick();
    tx_valid = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      if (rx_valid) begin
        lat = c;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (tx_ready !== 1'b0) begin
        errors++; $display("FAIL reset_tx_ready cyc%0d: got %b expected 0", i, tx_ready);
      end
    end
    checks++;
    if ({busy, rx_valid, rx_match, rx_parity_err, sr_serial_in} !== 5'b0 ||
        rx_data !== 8'h00 || mismatch_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b rv=%b rm=%b pe=%b si=%b rd=%h cnt=%0d expected all 0",
               busy, rx_valid, rx_match, rx_parity_err, sr_serial_in, rx_data, mismatch_cnt);
    end
    tx_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", tx_ready);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] d;
    logic exp_bit;
    d = 8'hA5;
    tx_data = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < NB + D; k++) begin
      if (k < W) exp_bit = d[W-1-k];
`ifdef PES_SISO_CTRL_PARITY_EN
      else if (k == W) exp_bit = ^d;
`endif
      else exp_bit = 1'b0;
      checks++;
      if (sr_serial_in !== exp_bit || busy !== 1'b1 || rx_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_shift k=%0d: got si=%b busy=%b rv=%b expected si=%b busy=1 rv=0",
                 k, sr_serial_in, busy, rx_valid, exp_bit);
      end
      tick();
    end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA5 || rx_match !== 1'b1 || mismatch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL single_done: got rv=%b rd=%h rm=%b cnt=%0d expected rv=1 rd=a5 rm=1 cnt=0",
               rx_valid, rx_data, rx_match, mismatch_cnt);
    end
    tick();
    checks++;
    if (rx_valid !== 1'b0 || tx_ready !== 1'b1 || rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_after: got rv=%b ready=%b rd=%h expected rv=0 ready=1 rd=a5",
               rx_valid, tx_ready, rx_data);
    end
  endtask

  task automatic test_back_to_back();
    int acc_t[2];
    logic [W-1:0] rxd[2];
    logic rxm[2];
    int na, nr;
    na = 0;
    nr = 0;
    acc_t[0] = 0; acc_t[1] = -100;
    rxd[0] = '0; rxd[1] = '0; rxm[0] = 1'b0; rxm[1] = 1'b0;
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    for (int c = 0; c < 80 && nr < 2; c++) begin
      if (tx_valid && tx_ready && na < 2) begin
        acc_t[na] = c;
        na++;
      end
      if (rx_valid && nr < 2) begin
        rxd[nr] = rx_data;
        rxm[nr] = rx_match;
        nr++;
      end
      tick();
      if (na == 1) tx_data = 8'hC3;
      if (na == 2) tx_valid = 1'b0;
    end
    tx_valid = 1'b0;
    checks++;
    if (na !== 2 || nr !== 2) begin
      errors++; $display("FAIL b2b_counts: got accepts=%0d frames=%0d expected 2 and 2", na, nr);
    end
    checks++;
    if (acc_t[1] - acc_t[0] !== NB + D + 2) begin
      errors++;
      $display("FAIL b2b_period: got %0d expected %0d", acc_t[1] - acc_t[0], NB + D + 2);
    end
    checks++;
    if (rxd[0] !== 8'h3C || rxm[0] !== 1'b1) begin
      errors++; $display("FAIL b2b_frame0: got rd=%h rm=%b expected 3c 1", rxd[0], rxm[0]);
    end
    checks++;
    if (rxd[1] !== 8'hC3 || rxm[1] !== 1'b1) begin
      errors++; $display("FAIL b2b_frame1: got rd=%h rm=%b expected c3 1", rxd[1], rxm[1]);
    end
  endtask

  task automatic test_fault();
    int lat;
    inv_all = 1'b1;
    run_frame(8'hA5, lat);
    checks++;
    if (lat !== Lat || rx_data !== 8'h5A || rx_match !== 1'b0 || mismatch_cnt !== 8'd1) begin
      errors++;
      $display("FAIL fault_first: got lat=%0d rd=%h rm=%b cnt=%0d expected lat=%0d rd=5a rm=0 cnt=1",
               lat, rx_data, rx_match, mismatch_cnt, Lat);
    end
    for (int f = 0; f < 254; f++) run_frame(8'hA5, lat);
    checks++;
    if (mismatch_cnt !== 8'd255) begin
      errors++; $display("FAIL fault_reach_255: got %0d expected 255", mismatch_cnt);
    end
    run_frame(8'hA5, lat);
    run_frame(8'hA5, lat);
    checks++;
    if (lat !== Lat || mismatch_cnt !== 8'd255 || rx_match !== 1'b0) begin
      errors++;
      $display("FAIL fault_saturate: got lat=%0d cnt=%0d rm=%b expected lat=%0d cnt=255 rm=0",
               lat, mismatch_cnt, rx_match, Lat);
    end
    inv_all = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    while (!tx_ready) tick();
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (tx_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_in_reset: got ready=%b busy=%b expected 0 1", tx_ready, busy);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || sr_serial_in !== 1'b0 || tx_ready !== 1'b1 || rx_valid !== 1'b0 ||
        mismatch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_idle: got busy=%b si=%b ready=%b rv=%b cnt=%0d expected 0 0 1 0 0",
               busy, sr_serial_in, tx_ready, rx_valid, mismatch_cnt);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (rx_valid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL mid_no_rx_valid: got %0d pulses expected 0", seen);
    end
    run_frame(8'hFF, lat);
    checks++;
    if (lat !== Lat || rx_data !== 8'hFF || rx_match !== 1'b1 || mismatch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_next_frame: got lat=%0d rd=%h rm=%b cnt=%0d expected lat=%0d rd=ff rm=1 cnt=0",
               lat, rx_data, rx_match, mismatch_cnt, Lat);
    end
    tick();
  endtask

`ifdef PES_SISO_CTRL_PARITY_EN
  task automatic test_parity();
    int lat;
    run_frame(8'h07, lat);
    checks++;
    if (lat !== 14 || rx_data !== 8'h07 || rx_parity_err !== 1'b0 || rx_match !== 1'b1) begin
      errors++;
      $display("FAIL parity_clean: got lat=%0d rd=%h pe=%b rm=%b expected 14 07 0 1",
               lat, rx_data, rx_parity_err, rx_match);
    end
    flip_par = 1'b1;
    run_frame(8'h07, lat);
    checks++;
    if (lat !== 14 || rx_data !== 8'h07 || rx_parity_err !== 1'b1 || rx_match !== 1'b0) begin
      errors++;
      $display("FAIL parity_flip: got lat=%0d rd=%h pe=%b rm=%b expected 14 07 1 0",
               lat, rx_data, rx_parity_err, rx_match);
    end
    flip_par = 1'b0;
    tick();
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_fault();
    test_reset_mid();
`ifdef PES_SISO_CTRL_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
